// File: rtl/bus_arbiter_rr_if.sv
// Master-side request/ack bundle plus the shared slave port of bus_arbiter_rr.
// The master modport is the arbiter's view; slave is the view of everything around it.
interface bus_arbiter_rr_if #(
  parameter int unsigned NM = 4,
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  localparam int unsigned IW = (NM > 1) ? $clog2(NM) : 1;

  logic [NM-1:0]    m_req;
  logic [NM-1:0]    m_rw;
  logic [NM*AW-1:0] m_addr;
  logic [NM*DW-1:0] m_wdata;
  logic [DW-1:0]    m_rdata;
  logic [NM-1:0]    m_ack;
  logic [NM-1:0]    m_err;
  logic [NM-1:0]    m_stall;
  logic             s_req;
  logic             s_rw;
  logic [AW-1:0]    s_addr;
  logic [DW-1:0]    s_wdata;
  logic [DW-1:0]    s_rdata;
  logic             s_rdy;
  logic [IW-1:0]    grant_id;

  modport master (
    input  m_req, m_rw, m_addr, m_wdata, s_rdata, s_rdy,
    output m_rdata, m_ack, m_err, m_stall, s_req, s_rw, s_addr, s_wdata, grant_id
  );

  modport slave (
    output m_req, m_rw, m_addr, m_wdata, s_rdata, s_rdy,
    input  m_rdata, m_ack, m_err, m_stall, s_req, s_rw, s_addr, s_wdata, grant_id
  );
endinterface

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter sharing one registered slave port among NM masters, with a
// watchdog that completes hung transactions with an error flag.
module bus_arbiter_rr #(
  parameter int unsigned NM = 4,
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32,
  parameter int unsigned TW = 8
) (
  input  logic             clk,
  input  logic             rst,
  bus_arbiter_rr_if.master bus
);
  localparam int unsigned IW = (NM > 1) ? $clog2(NM) : 1;
  localparam logic [TW-1:0] TmoLast = '1;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e        state_q;
  logic [IW-1:0] grant_q;
  logic [IW-1:0] last_q;
  logic [TW-1:0] cnt_q;
  logic          s_req_q;
  logic          s_rw_q;
  logic [AW-1:0] s_addr_q;
  logic [DW-1:0] s_wdata_q;
  logic [DW-1:0] m_rdata_q;
  logic [NM-1:0] m_ack_q;
  logic [NM-1:0] m_err_q;

  logic [NM-1:0] eligible;
  logic [NM-1:0] grant_onehot;
  logic [IW-1:0] winner;
  logic [IW-1:0] idx;
  logic          found;

  // A master being acked this cycle may still hold req; keep it out of the next pick.
  assign eligible = bus.m_req & ~m_ack_q;

  always_comb begin
    winner = last_q;
    idx    = '0;
    found  = 1'b0;
    for (int k = 1; k <= int'(NM); k++) begin
      idx = IW'((int'(last_q) + k) % int'(NM));
      if (!found && eligible[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    grant_onehot          = '0;
    grant_onehot[grant_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      last_q    <= IW'(NM - 1);
      cnt_q     <= '0;
      s_req_q   <= 1'b0;
      s_rw_q    <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      m_rdata_q <= '0;
      m_ack_q   <= '0;
      m_err_q   <= '0;
    end else begin
      m_ack_q <= '0;
      m_err_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (found) begin
            grant_q   <= winner;
            s_rw_q    <= bus.m_rw[winner];
            s_addr_q  <= bus.m_addr[int'(winner) * int'(AW) +: AW];
            s_wdata_q <= bus.m_wdata[int'(winner) * int'(DW) +: DW];
            s_req_q   <= 1'b1;
            cnt_q     <= '0;
            state_q   <= StBusy;
          end
        end
        StBusy: begin
          // s_rdy wins over a watchdog expiry landing in the same cycle.
          if (bus.s_rdy || (cnt_q == TmoLast)) begin
            m_rdata_q <= (bus.s_rdy && !s_rw_q) ? bus.s_rdata : '0;
            m_ack_q   <= grant_onehot;
            m_err_q   <= bus.s_rdy ? '0 : grant_onehot;
            s_req_q   <= 1'b0;
            last_q    <= grant_q;
            state_q   <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.m_rdata  = m_rdata_q;
  assign bus.m_ack    = m_ack_q;
  assign bus.m_err    = m_err_q;
  assign bus.m_stall  = bus.m_req & ~m_ack_q;
  assign bus.s_req    = s_req_q;
  assign bus.s_rw     = s_rw_q;
  assign bus.s_addr   = s_addr_q;
  assign bus.s_wdata  = s_wdata_q;
  assign bus.grant_id = grant_q;
endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr: directed scenarios plus a randomized run against a
// transaction-level round-robin model.
module tb_bus_arbiter_rr;
  localparam int unsigned NM = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TW = 4;
  localparam int unsigned IW = $clog2(NM);
  localparam int TMO = (1 << TW) - 1;

  logic clk;
  logic rst;
  int checks = 0;
  int errors = 0;

  bus_arbiter_rr_if #(.NM(NM), .AW(AW), .DW(DW)) bus ();

  bus_arbiter_rr #(.NM(NM), .AW(AW), .DW(DW), .TW(TW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.m_req   = '0;
    bus.m_rw    = '0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    bus.s_rdy   = 1'b0;
    bus.s_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    bus.m_req = 4'b1010;
    bus.s_rdy = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.s_req !== 1'b0 || bus.s_rw !== 1'b0 || bus.s_addr !== '0 || bus.s_wdata !== '0) begin
      errors++;
      $display("FAIL reset_slave: got req=%b rw=%b addr=%h wdata=%h, want all 0",
               bus.s_req, bus.s_rw, bus.s_addr, bus.s_wdata);
    end
    checks++;
    if (bus.m_ack !== '0 || bus.m_err !== '0 || bus.m_rdata !== '0) begin
      errors++;
      $display("FAIL reset_master: got ack=%b err=%b rdata=%h, want all 0",
               bus.m_ack, bus.m_err, bus.m_rdata);
    end
    checks++;
    if (bus.grant_id !== '0) begin
      errors++;
      $display("FAIL reset_grant_id: got %0d want 0", bus.grant_id);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_inputs();
    bus.s_rdy   = 1'b1;
    bus.s_rdata = 32'h5555AAAA;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (bus.s_req !== 1'b0 || bus.m_ack !== '0) begin
        errors++;
        $display("FAIL idle_rdy_ignored: got s_req=%b ack=%b want 0/0", bus.s_req, bus.m_ack);
      end
      tick();
    end
    bus.s_rdy = 1'b0;
  endtask

  task automatic test_single_read();
    do_reset();
    bus.m_req[2]           = 1'b1;
    bus.m_rw[2]            = 1'b0;
    bus.m_addr[2*AW +: AW] = 32'h10000004;
    @(negedge clk);
    checks++;
    if (bus.m_stall[2] !== 1'b1 || bus.s_req !== 1'b0) begin
      errors++;
      $display("FAIL read_c0: got stall2=%b s_req=%b want 1/0", bus.m_stall[2], bus.s_req);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.s_req !== 1'b1 || bus.s_addr !== 32'h10000004 || bus.grant_id !== 2'd2) begin
      errors++;
      $display("FAIL read_c1: got s_req=%b addr=%h gid=%0d want 1/10000004/2",
               bus.s_req, bus.s_addr, bus.grant_id);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.s_req !== 1'b1 || bus.m_stall[2] !== 1'b1) begin
      errors++;
      $display("FAIL read_c2: got s_req=%b stall2=%b want 1/1", bus.s_req, bus.m_stall[2]);
    end
    tick();
    bus.s_rdy   = 1'b1;
    bus.s_rdata = 32'hCAFEF00D;
    @(negedge clk);
    checks++;
    if (bus.s_req !== 1'b1 || bus.m_ack !== '0 || bus.m_stall[2] !== 1'b1) begin
      errors++;
      $display("FAIL read_c3: got s_req=%b ack=%b stall2=%b want 1/0000/1",
               bus.s_req, bus.m_ack, bus.m_stall[2]);
    end
    tick();
    bus.s_rdy   = 1'b0;
    bus.s_rdata = '0;
    @(negedge clk);
    checks++;
    if (bus.m_ack !== 4'b0100 || bus.m_err !== '0 || bus.m_rdata !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL read_ack: got ack=%b err=%b rdata=%h want 0100/0000/cafef00d",
               bus.m_ack, bus.m_err, bus.m_rdata);
    end
    checks++;
    if (bus.s_req !== 1'b0 || bus.m_stall[2] !== 1'b0) begin
      errors++;
      $display("FAIL read_c4: got s_req=%b stall2=%b want 0/0", bus.s_req, bus.m_stall[2]);
    end
    tick();
    bus.m_req[2] = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.m_ack !== '0 || bus.s_req !== 1'b0) begin
      errors++;
      $display("FAIL read_c5: got ack=%b s_req=%b want 0000/0", bus.m_ack, bus.s_req);
    end
    tick();
  endtask

  task automatic test_contention();
    int exp_id [2];
    bit got;
    exp_id[0] = 0;
    exp_id[1] = 3;
    do_reset();
    bus.m_req = 4'b1001;
    for (int t = 0; t < 2; t++) begin
      got = 1'b0;
      for (int w = 0; w < 10 && !got; w++) begin
        @(negedge clk);
        if (bus.s_req === 1'b1) got = 1'b1;
        else tick();
      end
      checks++;
      if (!got || bus.grant_id !== IW'(exp_id[t])) begin
        errors++;
        $display("FAIL contention_grant%0d: got s_req=%b gid=%0d want 1/%0d",
                 t, got, bus.grant_id, exp_id[t]);
      end
      tick();
      bus.s_rdy = 1'b1;
      @(negedge clk);
      tick();
      bus.s_rdy = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.m_ack !== (NM'(1) << exp_id[t])) begin
        errors++;
        $display("FAIL contention_ack%0d: got %b want %b", t, bus.m_ack, NM'(1) << exp_id[t]);
      end
      tick();
      bus.m_req[exp_id[t]] = 1'b0;
    end
  endtask

  task automatic test_fairness();
    int ack_cnt [NM];
    bit got;
    for (int i = 0; i < NM; i++) ack_cnt[i] = 0;
    do_reset();
    bus.m_req = '1;
    for (int t = 0; t < 12; t++) begin
      got = 1'b0;
      for (int w = 0; w < 10 && !got; w++) begin
        @(negedge clk);
        if (bus.s_req === 1'b1) got = 1'b1;
        else tick();
      end
      checks++;
      if (!got || bus.grant_id !== IW'(t % NM)) begin
        errors++;
        $display("FAIL fair_grant%0d: got s_req=%b gid=%0d want 1/%0d",
                 t, got, bus.grant_id, t % NM);
      end
      tick();
      bus.s_rdy = 1'b1;
      @(negedge clk);
      tick();
      bus.s_rdy = 1'b0;
      @(negedge clk);
      for (int i = 0; i < NM; i++) if (bus.m_ack[i] === 1'b1) ack_cnt[i]++;
      tick();
    end
    for (int i = 0; i < NM; i++) begin
      checks++;
      if (ack_cnt[i] != 3) begin
        errors++;
        $display("FAIL fair_count%0d: got %0d acks want 3", i, ack_cnt[i]);
      end
    end
    clear_inputs();
  endtask

  task automatic test_write_withdraw();
    bit got;
    do_reset();
    bus.m_rw[1]             = 1'b1;
    bus.m_addr[1*AW +: AW]  = 32'hF0200000;
    bus.m_wdata[1*DW +: DW] = 32'h000000A5;
    bus.m_req[1]            = 1'b1;
    got = 1'b0;
    for (int w = 0; w < 10 && !got; w++) begin
      @(negedge clk);
      if (bus.s_req === 1'b1) got = 1'b1;
      else tick();
    end
    checks++;
    if (!got || bus.s_rw !== 1'b1 || bus.s_wdata !== 32'h000000A5 ||
        bus.s_addr !== 32'hF0200000 || bus.grant_id !== 2'd1) begin
      errors++;
      $display("FAIL write_fields: got req=%b rw=%b wdata=%h addr=%h gid=%0d",
               got, bus.s_rw, bus.s_wdata, bus.s_addr, bus.grant_id);
    end
    tick();
    bus.m_req[1] = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.s_req !== 1'b1) begin
      errors++;
      $display("FAIL withdraw_hold: got s_req=%b want 1", bus.s_req);
    end
    tick();
    bus.s_rdy   = 1'b1;
    bus.s_rdata = 32'hDEADBEEF;
    @(negedge clk);
    tick();
    bus.s_rdy = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.m_ack !== 4'b0010 || bus.m_rdata !== '0 || bus.m_err !== '0) begin
      errors++;
      $display("FAIL write_ack: got ack=%b rdata=%h err=%b want 0010/0/0000",
               bus.m_ack, bus.m_rdata, bus.m_err);
    end
    tick();
  endtask

  task automatic test_timeout();
    bit got;
    int early;
    do_reset();
    bus.m_req[0] = 1'b1;
    bus.s_rdata  = 32'h12345678;
    got = 1'b0;
    for (int w = 0; w < 10 && !got; w++) begin
      @(negedge clk);
      if (bus.s_req === 1'b1) got = 1'b1;
      else tick();
    end
    early = 0;
    for (int j = 1; j <= TMO; j++) begin
      tick();
      @(negedge clk);
      if (bus.m_ack !== '0) early++;
    end
    checks++;
    if (!got || early != 0) begin
      errors++;
      $display("FAIL timeout_early: got s_req=%b early_acks=%0d want 1/0", got, early);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.m_ack !== 4'b0001 || bus.m_err !== 4'b0001 || bus.m_rdata !== '0 ||
        bus.s_req !== 1'b0) begin
      errors++;
      $display("FAIL timeout_ack: got ack=%b err=%b rdata=%h s_req=%b want 0001/0001/0/0",
               bus.m_ack, bus.m_err, bus.m_rdata, bus.s_req);
    end
    tick();
    bus.m_req = '0;
    @(negedge clk);
    checks++;
    if (bus.s_req !== 1'b0 || bus.m_ack !== '0 || bus.m_err !== '0) begin
      errors++;
      $display("FAIL timeout_idle: got s_req=%b ack=%b err=%b want 0", bus.s_req, bus.m_ack,
               bus.m_err);
    end
    tick();
  endtask

  task automatic test_reset_mid_busy();
    bit got;
    int acks;
    do_reset();
    bus.m_req = 4'b0001;
    got = 1'b0;
    for (int w = 0; w < 10 && !got; w++) begin
      @(negedge clk);
      if (bus.s_req === 1'b1) got = 1'b1;
      else tick();
    end
    tick();
    bus.s_rdy = 1'b1;
    @(negedge clk);
    tick();
    bus.s_rdy = 1'b0;
    @(negedge clk);
    checks++;
    if (!got || bus.m_ack !== 4'b0001) begin
      errors++;
      $display("FAIL rstbusy_first: got s_req=%b ack=%b want 1/0001", got, bus.m_ack);
    end
    tick();
    bus.m_req = 4'b0011;
    got = 1'b0;
    for (int w = 0; w < 10 && !got; w++) begin
      @(negedge clk);
      if (bus.s_req === 1'b1) got = 1'b1;
      else tick();
    end
    checks++;
    if (!got || bus.grant_id !== 2'd1) begin
      errors++;
      $display("FAIL rstbusy_grant1: got s_req=%b gid=%0d want 1/1", got, bus.grant_id);
    end
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.s_req !== 1'b0 || bus.grant_id !== '0 || bus.m_ack !== '0) begin
      errors++;
      $display("FAIL rstbusy_async: got s_req=%b gid=%0d ack=%b want 0/0/0000",
               bus.s_req, bus.grant_id, bus.m_ack);
    end
    @(posedge clk);
    #1;
    rst  = 1'b0;
    got  = 1'b0;
    acks = 0;
    for (int w = 0; w < 10 && !got; w++) begin
      @(negedge clk);
      if (bus.m_ack !== '0) acks++;
      if (bus.s_req === 1'b1) got = 1'b1;
      else tick();
    end
    checks++;
    if (!got || bus.grant_id !== 2'd0 || acks != 0) begin
      errors++;
      $display("FAIL rstbusy_prio: got s_req=%b gid=%0d acks=%0d want 1/0/0",
               got, bus.grant_id, acks);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_random();
    logic [NM-1:0] req_v;
    logic [NM-1:0] rw_v;
    logic [NM-1:0] exp_ack;
    logic [NM-1:0] prev_elig;
    logic [AW-1:0] addr_v [NM];
    logic [DW-1:0] wdata_v [NM];
    logic [DW-1:0] slave_data;
    logic [DW-1:0] exp_rdata;
    logic          prev_sreq;
    logic          exp_sreq;
    logic          exp_err;
    int last, owner, ack_cyc, rdy_cyc, d, r, winner;
    do_reset();
    req_v      = '0;
    rw_v       = '0;
    exp_ack    = '0;
    prev_elig  = '0;
    prev_sreq  = 1'b0;
    exp_err    = 1'b0;
    exp_rdata  = '0;
    slave_data = '0;
    last       = NM - 1;
    owner      = 0;
    ack_cyc    = -1;
    rdy_cyc    = -1;
    for (int i = 0; i < NM; i++) begin
      addr_v[i]  = '0;
      wdata_v[i] = '0;
    end
    for (int c = 0; c < 3000; c++) begin
      // Masters drop req after their ack cycle and occasionally start a new transaction.
      for (int i = 0; i < NM; i++) begin
        if (exp_ack[i]) begin
          req_v[i] = 1'b0;
        end else if (!req_v[i] && $urandom_range(3) == 0) begin
          req_v[i]   = 1'b1;
          rw_v[i]    = 1'($urandom_range(1));
          addr_v[i]  = $urandom;
          wdata_v[i] = $urandom;
        end
        bus.m_addr[i*AW +: AW]  = addr_v[i];
        bus.m_wdata[i*DW +: DW] = wdata_v[i];
      end
      bus.m_req   = req_v;
      bus.m_rw    = rw_v;
      bus.s_rdy   = (c == rdy_cyc);
      bus.s_rdata = (c == rdy_cyc) ? slave_data : $urandom;
      @(negedge clk);
      exp_ack = (c == ack_cyc) ? (NM'(1) << owner) : '0;
      checks++;
      if (bus.m_ack !== exp_ack) begin
        errors++;
        $display("FAIL rnd_ack c=%0d: got %b want %b", c, bus.m_ack, exp_ack);
      end
      checks++;
      if (bus.m_err !== (exp_err ? exp_ack : '0)) begin
        errors++;
        $display("FAIL rnd_err c=%0d: got %b want %b", c, bus.m_err, exp_err ? exp_ack : '0);
      end
      if (exp_ack != '0) begin
        checks++;
        if (bus.m_rdata !== exp_rdata) begin
          errors++;
          $display("FAIL rnd_rdata c=%0d: got %h want %h", c, bus.m_rdata, exp_rdata);
        end
      end
      checks++;
      if (bus.m_stall !== (req_v & ~exp_ack)) begin
        errors++;
        $display("FAIL rnd_stall c=%0d: got %b want %b", c, bus.m_stall, req_v & ~exp_ack);
      end
      exp_sreq = prev_sreq ? (c != ack_cyc) : (prev_elig != '0);
      checks++;
      if (bus.s_req !== exp_sreq) begin
        errors++;
        $display("FAIL rnd_sreq c=%0d: got %b want %b", c, bus.s_req, exp_sreq);
      end
      if (bus.s_req === 1'b1 && !prev_sreq) begin
        winner = -1;
        for (int k = 1; k <= NM; k++) begin
          if (winner < 0 && prev_elig[(last + k) % NM]) winner = (last + k) % NM;
        end
        if (winner < 0) winner = 0;
        checks++;
        if (bus.grant_id !== IW'(winner)) begin
          errors++;
          $display("FAIL rnd_grant c=%0d: got %0d want %0d", c, bus.grant_id, winner);
        end
        checks++;
        if (bus.s_addr !== addr_v[winner] || bus.s_rw !== rw_v[winner] ||
            bus.s_wdata !== wdata_v[winner]) begin
          errors++;
          $display("FAIL rnd_fields c=%0d: got %h/%b/%h want %h/%b/%h", c, bus.s_addr,
                   bus.s_rw, bus.s_wdata, addr_v[winner], rw_v[winner], wdata_v[winner]);
        end
        last       = winner;
        owner      = winner;
        r          = int'($urandom_range(9));
        d          = (r == 0) ? TMO : (r == 1) ? TMO + 1 : 1 + int'($urandom_range(3));
        slave_data = $urandom;
        if (d <= TMO) begin
          rdy_cyc   = c + d;
          ack_cyc   = c + d + 1;
          exp_err   = 1'b0;
          exp_rdata = rw_v[winner] ? '0 : slave_data;
        end else begin
          rdy_cyc   = -1;
          ack_cyc   = c + TMO + 1;
          exp_err   = 1'b1;
          exp_rdata = '0;
        end
      end
      prev_sreq = bus.s_req;
      prev_elig = req_v & ~exp_ack;
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_fairness();
    test_write_withdraw();
    test_timeout();
    test_reset_mid_busy();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
